// File: rtl/control_unit.sv
// Control FSM for the 8-bit accumulator datapath.
// Each instruction runs START -> FETCH -> DECODE -> execute.
// INPUT waits on the Enter key. HALT stays put until reset.
// The DP control word is decoded from the current state.
// JZ/JPOS (PCload) and INPUT (Aload) are Mealy: they also depend on a live input.
module control_unit #(
  parameter bit ENTER_RELEASE = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic       Sub,
  output logic       Halt,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_SUB    = 4'd6,
    S_INPUT  = 4'd7,
    S_INREL  = 4'd8,
    S_JZ     = 4'd9,
    S_JPOS   = 4'd10,
    S_HALT   = 4'd11
  } state_e;

  // The register is plain logic so that codes 12-15 can be held and then recovered.
  logic [3:0] state, state_nxt;

  assign State = state;

  // State register; reset aborts any instruction in progress.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_START;
    else        state <= state_nxt;
  end

  // Next state and control word. Unused codes fall back to START.
  always_comb begin
    state_nxt = S_START;
    IRload    = 1'b0;
    JMPmux    = 1'b0;
    PCload    = 1'b0;
    Meminst   = 1'b0;
    MemWr     = 1'b0;
    Asel      = 2'b00;
    Aload     = 1'b0;
    Sub       = 1'b0;
    Halt      = 1'b0;
    case (state)
      S_START:  state_nxt = S_FETCH;
      S_FETCH: begin
        IRload    = 1'b1;
        PCload    = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        Meminst = 1'b1;
        case (IR)
          3'b000:  state_nxt = S_LOAD;
          3'b001:  state_nxt = S_STORE;
          3'b010:  state_nxt = S_ADD;
          3'b011:  state_nxt = S_SUB;
          3'b100:  state_nxt = S_INPUT;
          3'b101:  state_nxt = S_JZ;
          3'b110:  state_nxt = S_JPOS;
          default: state_nxt = S_HALT;
        endcase
      end
      S_LOAD: begin
        Meminst = 1'b1;
        Asel    = 2'b10;
        Aload   = 1'b1;
      end
      S_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      S_ADD: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
      end
      S_SUB: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
        Sub     = 1'b1;
      end
      S_INPUT: begin
        // A captures the switch value on the Enter cycle only.
        Asel  = 2'b01;
        Aload = Enter;
        if (!Enter)            state_nxt = S_INPUT;
        else if (ENTER_RELEASE) state_nxt = S_INREL;
        else                   state_nxt = S_START;
      end
      S_INREL:  state_nxt = Enter ? S_INREL : S_START;
      S_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      S_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      S_HALT: begin
        Halt      = 1'b1;
        state_nxt = S_HALT;
      end
      default:  state_nxt = S_START;
    endcase
  end

endmodule
